// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit bridging the memory stage to a word-addressed data memory.
// One request in flight; lane-aligned byte enables, sign/zero-extended loads, misalign/illegal/timeout faults.
`default_nettype none

module data_mem_lsu #(
   parameter int N       = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [N-1:0]      wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N-1:0]      rdata,
   output logic [1:0]        rsp_fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [N/8-1:0]    mem_be,
   output logic [N-1:0]      mem_wdata,
   input  logic [N-1:0]      mem_rdata,
   input  logic              mem_ack
);

   localparam int NB      = N / 8;
   localparam int OFF_W   = $clog2(NB);
   localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] FLT_OK    = 2'b00;
   localparam logic [1:0] FLT_ALIGN = 2'b01;
   localparam logic [1:0] FLT_TMO   = 2'b10;
   localparam logic [1:0] FLT_ILL   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, state_nx;

   logic              is_load, is_store, legal, misal;
   logic [1:0]        size;
   logic [OFF_W-1:0]  off;
   logic [7:0]        be8;
   logic [63:0]       dmask64;
   logic [NB-1:0]     be_nx;
   logic [N-1:0]      wdata_nx;

   logic              ld_q;
   logic [2:0]        f3_q;
   logic [OFF_W-1:0]  off_q;
   logic [CNT_W-1:0]  cnt;
   logic [N-1:0]      rd_shift;
   logic [63:0]       rd64, ext64;
   logic [N-1:0]      ld_data;
   logic              timeout_hit;

   assign size = funct3[1:0];
   assign off  = addr[OFF_W-1:0];

   // Request decode: legality by opcode/funct3, then natural alignment by size.
   always_comb begin
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      legal    = 1'b0;
      if (is_load) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110:                         legal = (N == 64);
            default:                                legal = 1'b0;
         endcase
      end else if (is_store) begin
         case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:                 legal = (N == 64);
            default:                legal = 1'b0;
         endcase
      end
      case (size)
         2'd1:    misal = addr[0];
         2'd2:    misal = |addr[1:0];
         2'd3:    misal = |addr[2:0];
         default: misal = 1'b0;
      endcase
   end

   always_comb begin
      case (size)
         2'd0:    begin be8 = 8'h01; dmask64 = 64'h0000_0000_0000_00FF; end
         2'd1:    begin be8 = 8'h03; dmask64 = 64'h0000_0000_0000_FFFF; end
         2'd2:    begin be8 = 8'h0F; dmask64 = 64'h0000_0000_FFFF_FFFF; end
         default: begin be8 = 8'hFF; dmask64 = 64'hFFFF_FFFF_FFFF_FFFF; end
      endcase
   end

   assign be_nx    = be8[NB-1:0] << off;
   assign wdata_nx = (wdata & dmask64[N-1:0]) << {off, 3'b000};

   // Load return path: bring the addressed lane down to bit 0, then extend.
   assign rd_shift = mem_rdata >> {off_q, 3'b000};
   assign rd64     = 64'(rd_shift);

   always_comb begin
      case (f3_q[1:0])
         2'd0:    ext64 = {{56{~f3_q[2] & rd64[7]}},  rd64[7:0]};
         2'd1:    ext64 = {{48{~f3_q[2] & rd64[15]}}, rd64[15:0]};
         2'd2:    ext64 = {{32{~f3_q[2] & rd64[31]}}, rd64[31:0]};
         default: ext64 = rd64;
      endcase
   end

   assign ld_data     = ext64[N-1:0];
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST)) && !mem_ack;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign mem_req   = (state == ISSUE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = (!legal || misal) ? RESP : ISSUE;
         ISSUE:   if (mem_ack || timeout_hit) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= '0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         rsp_fault <= FLT_OK;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  ld_q  <= is_load;
                  f3_q  <= funct3;
                  off_q <= off;
                  cnt   <= '0;
                  rdata <= '0;
                  if (!legal) begin
                     rsp_fault <= FLT_ILL;
                  end else if (misal) begin
                     rsp_fault <= FLT_ALIGN;
                  end else begin
                     rsp_fault <= FLT_OK;
                     mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_we    <= is_store;
                     mem_be    <= be_nx;
                     mem_wdata <= is_store ? wdata_nx : '0;
                  end
               end
            end
            ISSUE: begin
               if (mem_ack) begin
                  rdata     <= ld_q ? ld_data : '0;
                  rsp_fault <= FLT_OK;
                  mem_we    <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (timeout_hit) begin
                     rdata     <= '0;
                     rsp_fault <= FLT_TMO;
                     mem_we    <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
// Directed testbench for data_mem_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
`default_nettype none

module tb_data_mem_lsu;

   localparam logic [6:0] LD_OP = 7'b0000011;
   localparam logic [6:0] ST_OP = 7'b0100011;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 32-bit instance
   logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
   logic [6:0]  a_opcode;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr, a_wdata, a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [1:0]  a_rsp_fault;
   logic        a_mem_req, a_mem_we, a_mem_ack;
   logic [3:0]  a_mem_be;

   // 64-bit instance
   logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic [6:0]  b_opcode;
   logic [2:0]  b_funct3;
   logic [31:0] b_addr, b_mem_addr;
   logic [63:0] b_wdata, b_rdata, b_mem_wdata, b_mem_rdata;
   logic [1:0]  b_rsp_fault;
   logic        b_mem_req, b_mem_we, b_mem_ack;
   logic [7:0]  b_mem_be;

   data_mem_lsu #(.N(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .opcode(a_opcode), .funct3(a_funct3), .addr(a_addr), .wdata(a_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rdata(a_rdata), .rsp_fault(a_rsp_fault),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack)
   );

   data_mem_lsu #(.N(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .opcode(b_opcode), .funct3(b_funct3), .addr(b_addr), .wdata(b_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rdata(b_rdata), .rsp_fault(b_rsp_fault),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic req_a(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] ad, input logic [31:0] wd);
      a_req_valid = 1'b1; a_opcode = op; a_funct3 = f3; a_addr = ad; a_wdata = wd;
      tick();
      a_req_valid = 1'b0;
   endtask

   task automatic ack_a(input logic [31:0] d);
      a_mem_ack = 1'b1; a_mem_rdata = d;
      tick();
      a_mem_ack = 1'b0; a_mem_rdata = '0;
   endtask

   task automatic rsp_a();
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
   endtask

   task automatic req_b(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] ad, input logic [63:0] wd);
      b_req_valid = 1'b1; b_opcode = op; b_funct3 = f3; b_addr = ad; b_wdata = wd;
      tick();
      b_req_valid = 1'b0;
   endtask

   task automatic ack_b(input logic [63:0] d);
      b_mem_ack = 1'b1; b_mem_rdata = d;
      tick();
      b_mem_ack = 1'b0; b_mem_rdata = '0;
   endtask

   task automatic rsp_b();
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi;
      rst_n = 1'b0;
      a_req_valid = 0; a_rsp_ready = 0; a_opcode = 0; a_funct3 = 0; a_addr = 0;
      a_wdata = 0; a_mem_rdata = 0; a_mem_ack = 0;
      b_req_valid = 0; b_rsp_ready = 0; b_opcode = 0; b_funct3 = 0; b_addr = 0;
      b_wdata = 0; b_mem_rdata = 0; b_mem_ack = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", a_req_ready, 1);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_mem_req", a_mem_req, 0);
      chk("rst_outputs", {a_mem_we, a_mem_be, a_rsp_fault}, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_b_req_ready", b_req_ready, 1);
      rst_n = 1'b1;
      tick();

      // LB at 0x103, ack on the second ISSUE cycle
      req_a(LD_OP, 3'b000, 32'h103, 0);
      chk("lb_mem_req", a_mem_req, 1);
      chk("lb_mem_addr", a_mem_addr, 32'h100);
      chk("lb_mem_be", a_mem_be, 4'b1000);
      chk("lb_mem_we", a_mem_we, 0);
      chk("lb_req_ready", a_req_ready, 0);
      tick();
      chk("lb_no_rsp_early", a_rsp_valid, 0);
      ack_a(32'h80FF_1234);
      chk("lb_rsp_valid", a_rsp_valid, 1);
      chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
      chk("lb_fault", a_rsp_fault, 0);
      chk("lb_mem_req_off", a_mem_req, 0);
      rsp_a();
      chk("lb_req_ready_after", a_req_ready, 1);

      // LHU / LH at 0x102, ack in the first ISSUE cycle
      req_a(LD_OP, 3'b101, 32'h102, 0);
      chk("lhu_mem_be", a_mem_be, 4'b1100);
      ack_a(32'h80FF_1234);
      chk("lhu_rdata", a_rdata, 32'h0000_80FF);
      rsp_a();
      req_a(LD_OP, 3'b001, 32'h102, 0);
      ack_a(32'h80FF_1234);
      chk("lh_rdata", a_rdata, 32'hFFFF_80FF);
      rsp_a();

      // SH at 0x102
      req_a(ST_OP, 3'b001, 32'h102, 32'h1234_ABCD);
      chk("sh_mem_we", a_mem_we, 1);
      chk("sh_mem_be", a_mem_be, 4'b1100);
      chk("sh_mem_wdata", a_mem_wdata, 32'hABCD_0000);
      chk("sh_mem_addr", a_mem_addr, 32'h100);
      ack_a(32'h5555_5555);
      chk("sh_rdata", a_rdata, 0);
      chk("sh_fault", a_rsp_fault, 0);
      rsp_a();

      // Misaligned LW and illegal LD on the 32-bit bus
      req_a(LD_OP, 3'b010, 32'h101, 0);
      chk("lw_mis_mem_req", a_mem_req, 0);
      chk("lw_mis_rsp_valid", a_rsp_valid, 1);
      chk("lw_mis_fault", a_rsp_fault, 2'b01);
      rsp_a();
      req_a(LD_OP, 3'b011, 32'h100, 0);
      chk("ld32_ill_mem_req", a_mem_req, 0);
      chk("ld32_ill_fault", a_rsp_fault, 2'b11);
      rsp_a();
      req_a(ST_OP, 3'b100, 32'h100, 0);
      chk("st_ill_fault", a_rsp_fault, 2'b11);
      rsp_a();

      // Timeout with TIMEOUT=4
      req_a(LD_OP, 3'b010, 32'h10, 0);
      hi = 0;
      for (int i = 0; i < 12 && !a_rsp_valid; i++) begin
         if (a_mem_req) hi++;
         tick();
      end
      chk("tmo_req_cycles", 64'(hi), 4);
      chk("tmo_rsp_valid", a_rsp_valid, 1);
      chk("tmo_fault", a_rsp_fault, 2'b10);
      chk("tmo_rdata", a_rdata, 0);
      ack_a(32'hDEAD_BEEF);
      chk("tmo_late_ack_rdata", a_rdata, 0);
      chk("tmo_late_ack_fault", a_rsp_fault, 2'b10);
      rsp_a();
      ack_a(32'h1234_5678);
      chk("idle_ack_rsp_valid", a_rsp_valid, 0);
      chk("idle_ack_mem_req", a_mem_req, 0);

      // Back-pressure: LBU at 0x101, then hold rsp_ready low with a pending request
      req_a(LD_OP, 3'b100, 32'h101, 0);
      ack_a(32'h0000_AB00);
      chk("lbu_rdata", a_rdata, 32'h0000_00AB);
      a_req_valid = 1'b1; a_opcode = ST_OP; a_funct3 = 3'b010;
      a_addr = 32'h20; a_wdata = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_rsp_valid", a_rsp_valid, 1);
         chk("bp_rdata", a_rdata, 32'h0000_00AB);
         chk("bp_fault", a_rsp_fault, 0);
         chk("bp_req_ready", a_req_ready, 0);
         chk("bp_mem_req", a_mem_req, 0);
      end
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk("bp_ready_after_hs", a_req_ready, 1);
      chk("bp_not_yet_issued", a_mem_req, 0);
      tick();
      a_req_valid = 1'b0;
      chk("bp_sw_mem_req", a_mem_req, 1);
      chk("bp_sw_mem_we", a_mem_we, 1);
      chk("bp_sw_mem_be", a_mem_be, 4'b1111);
      chk("bp_sw_mem_wdata", a_mem_wdata, 32'hCAFE_F00D);
      chk("bp_sw_mem_addr", a_mem_addr, 32'h20);
      ack_a(0);
      rsp_a();

      // 64-bit bus
      req_b(LD_OP, 3'b110, 32'h14, 0);
      chk("lwu64_mem_be", b_mem_be, 8'hF0);
      chk("lwu64_mem_addr", b_mem_addr, 32'h10);
      ack_b(64'h89AB_CDEF_0123_4567);
      chk("lwu64_rdata", b_rdata, 64'h0000_0000_89AB_CDEF);
      rsp_b();
      req_b(LD_OP, 3'b010, 32'h14, 0);
      ack_b(64'h89AB_CDEF_0123_4567);
      chk("lw64_rdata", b_rdata, 64'hFFFF_FFFF_89AB_CDEF);
      rsp_b();
      req_b(LD_OP, 3'b011, 32'h14, 0);
      chk("ld64_mis_mem_req", b_mem_req, 0);
      chk("ld64_mis_fault", b_rsp_fault, 2'b01);
      rsp_b();
      req_b(7'h33, 3'b000, 32'h14, 0);
      chk("op33_fault", b_rsp_fault, 2'b11);
      rsp_b();
      req_b(ST_OP, 3'b011, 32'h8, 64'h1122_3344_5566_7788);
      chk("sd64_mem_be", b_mem_be, 8'hFF);
      chk("sd64_mem_wdata", b_mem_wdata, 64'h1122_3344_5566_7788);
      ack_b(0);
      rsp_b();
      req_b(ST_OP, 3'b000, 32'h0F, 64'h0000_0000_0000_00A5);
      chk("sb64_mem_be", b_mem_be, 8'h80);
      chk("sb64_mem_wdata", b_mem_wdata, 64'hA500_0000_0000_0000);
      ack_b(0);
      rsp_b();

      // Reset asserted mid-ISSUE
      req_b(LD_OP, 3'b010, 32'h8, 0);
      chk("rst_mid_mem_req_before", b_mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req_async", b_mem_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      ack_b(64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_mid_rsp_valid", b_rsp_valid, 0);
      chk("rst_mid_req_ready", b_req_ready, 1);
      chk("rst_mid_rdata", b_rdata, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Parametrised load/store unit between the core's memory stage and a word-addressed data memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Issues an aligned memory transaction with byte enables and waits for a variable-latency acknowledge.
- Returns lane-shifted, sign- or zero-extended load data with a fault code.
- Supersedes the purely combinational load-extension logic: adds byte-lane selection, store lane placement, alignment checking, a timeout and back-pressure.

Parameters:
N, 32, data bus width in bits; legal values 32 or 64.
ADDR_W, 32, address width in bits.
TIMEOUT, 16, maximum cycles to wait for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request
opcode  in  7  instruction opcode (LOAD 7'b0000011, STORE 7'b0100011)
funct3  in  3  access size and signedness
addr  in  ADDR_W  byte address
wdata  in  N  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rdata  out  N  extended load data; 0 for stores and faults
rsp_fault  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal opcode/funct3
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  addr with low log2(N/8) bits cleared
mem_be  out  N/8  byte enables
mem_wdata  out  N  lane-placed store data
mem_rdata  in  N  memory read data, valid when mem_ack = 1
mem_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE.
  - req_ready = 1; rsp_valid, mem_req and mem_we = 0.
  - mem_addr, mem_be, mem_wdata, rdata, rsp_fault and the wait counter = 0.
  - Reset asserted mid-transaction drops mem_req immediately. A later mem_ack is ignored.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch opcode, funct3, addr and wdata, then decode.
  - Illegal opcode or funct3 -> RESP with fault 11. LD, LWU and SD are legal only when N = 64.
  - Misaligned access -> RESP with fault 01. Misaligned means halfword with addr[0] ≠ 0, word with addr[1:0] ≠ 0, or doubleword with addr[2:0] ≠ 0.
  - Otherwise -> ISSUE. No mem_req is asserted on a faulted request.
- Size encodings:
  - Loads: funct3 LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
  - Stores: funct3 SB 000, SH 001, SW 010, SD 011.
- ISSUE:
  - mem_req = 1 and mem_addr, mem_we, mem_be and mem_wdata are held stable until ack or timeout. mem_ack may arrive in the first ISSUE cycle.
  - Lane offset is off = addr[log2(N/8)-1:0].
  - mem_be = size mask << off, where the size mask is 1, 3, F or FF.
  - mem_wdata = wdata masked to the access size, shifted left by 8*off. Loads drive mem_be for the accessed bytes, mem_we = 0 and mem_wdata = 0.
  - On mem_ack: register rdata. For loads, rdata = extend(mem_rdata >> 8*off), sign- or zero-extended per funct3 to N bits. For stores, rdata = 0. Set fault = 00 and go to RESP.
  - The wait counter increments each ISSUE cycle without ack. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT, drop mem_req, set fault 10 and rdata 0, and go to RESP.
- RESP:
  - rsp_valid = 1; rdata and rsp_fault are held stable; req_ready = 0.
  - On rsp_ready, go to IDLE and clear the counter.
  - req_ready rises in the cycle after the handshake; there is no request pipelining.
- Latency:
  - Accept at cycle 0; mem_req is high from cycle 1.
  - An ack at cycle k gives rsp_valid from cycle k+1.
  - A faulted request gives rsp_valid at cycle 1.
- mem_ack outside ISSUE is ignored. req_valid outside IDLE is not accepted.

Test Plan:
1. N=32, LB at addr 0x103, mem_rdata 0x80FF1234, ack after 2 cycles -> mem_addr 0x100, mem_be 4'b1000, rdata 0xFFFFFF80, fault 00, rsp_valid 3 cycles after accept.
2. LHU at 0x102, mem_rdata 0x80FF1234, ack in the first ISSUE cycle -> mem_be 4'b1100, rdata 0x000080FF. The same access as LH -> rdata 0xFFFF80FF.
3. SH at 0x102, wdata 0x1234ABCD -> mem_we 1, mem_be 4'b1100, mem_wdata 0xABCD0000, mem_addr 0x100; after ack, rdata 0 and fault 00. LW at 0x101 -> mem_req never asserted, rsp at cycle 1 with fault 01.
4. TIMEOUT=4, LW at 0x10 with mem_ack held low -> mem_req high for exactly 4 cycles, then rsp_fault 10 and rdata 0. A late mem_ack is ignored.
5. Back-pressure: rsp_ready low for 3 cycles after rsp_valid -> rdata and rsp_fault stable, req_ready 0, a new req_valid is not accepted. Accepted in the cycle after rsp_ready.
6. N=64: LWU at 0x14, mem_rdata 0x89ABCDEF_01234567 -> rdata 0x00000000_89ABCDEF. LD at 0x14 -> fault 01. Opcode 0x33 -> fault 11. rst_n pulsed low mid-ISSUE -> mem_req falls asynchronously, req_ready 1 after release.
